// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states and an
// funct3 legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension for byte, halfword and word loads.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {off, 3'b000};
        sel_b   = shifted[7:0];
        sel_h   = off[1] ? word[31:16] : word[15:0];
        data    = word;
        case (f3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   data = {24'b0, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   data = {16'b0, sel_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: req/ready handshake, LATENCY wait states, byte/half/word RAM access.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into faults instead of aligning.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  f3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam bit          DIRECT   = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT = DIRECT ? 4'd0 : 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  f3_q;
    logic        err_q;
    logic        commit;

    logic        a_we;
    logic [31:0] a_addr, a_wdata;
    logic [2:0]  a_f3;

    logic        addr_fault, f3_fault, mis_fault, acc_err;
    logic [1:0]  off;
    logic [AW-1:0] idx;
    logic [3:0]  wstrb;
    logic [31:0] wlanes, rd_word, ld_data;

    logic [31:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (DIRECT) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req) begin
                we_q    <= we;
                addr_q  <= addr;
                f3_q    <= f3;
                wdata_q <= wdata;
            end
            if (commit) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || a_we) ? 32'd0 : ld_data;
            end
        end
    end

    // With zero latency the commit happens on the accept edge, so use the live request.
    always_comb begin
        a_we    = DIRECT ? we    : we_q;
        a_addr  = DIRECT ? addr  : addr_q;
        a_f3    = DIRECT ? f3    : f3_q;
        a_wdata = DIRECT ? wdata : wdata_q;
    end

    always_comb begin
        addr_fault = ((a_addr >> (AW + 2)) != 32'd0);
        f3_fault   = !f3_legal(a_f3) || (a_we && a_f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_fault  = (((a_f3 == F3_H) || (a_f3 == F3_HU)) && a_addr[0]) ||
                     ((a_f3 == F3_W) && (a_addr[1:0] != 2'b00));
        off        = a_addr[1:0];
`else
        mis_fault  = 1'b0;
        if (a_f3 == F3_W) begin
            off = 2'b00;
        end else if ((a_f3 == F3_H) || (a_f3 == F3_HU)) begin
            off = {a_addr[1], 1'b0};
        end else begin
            off = a_addr[1:0];
        end
`endif
        acc_err = addr_fault || f3_fault || mis_fault;
        idx     = a_addr[AW+1:2];
    end

    always_comb begin
        wstrb  = 4'b0000;
        wlanes = a_wdata;
        case (a_f3)
            F3_B: begin
                wstrb  = 4'b0001 << off;
                wlanes = {4{a_wdata[7:0]}};
            end
            F3_H: begin
                wstrb  = off[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{a_wdata[15:0]}};
            end
            F3_W:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    // RAM is not reset; writes share the commit edge with the read capture.
    always_ff @(posedge clk) begin
        if (!rst && commit && a_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[idx];

    load_align u_load_align (
        .word (rd_word),
        .off  (off),
        .f3   (a_f3),
        .data (ld_data)
    );

    assign ready = (state_q == StResp);
    assign err   = ready & err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp with a byte-level reference model and per-cycle compare.
module tb_data_mem_resp;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    data_mem_resp #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .f3    (f3),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .err   (err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, edge_n);
    endtask

    // Byte-addressed reference memory.
    logic [7:0] mem_m [4*DEPTH];

    function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] f,
                                  input logic [31:0] d, output logic [31:0] rd, output logic e);
        int unsigned size;
        int unsigned ea;
        logic [31:0] v;
        rd   = 32'd0;
        e    = 1'b0;
        size = 1;
        case (f)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        e = 1'b1;
        endcase
        if (w && f[2]) e = 1'b1;
        if (a >= 32'(4 * DEPTH)) e = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % size != 0) e = 1'b1;
`endif
        if (e) return;
        ea = a - (a % size);
        if (w) begin
            for (int i = 0; i < int'(size); i++) mem_m[ea + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mem_m[ea + i];
            if (!f[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endfunction

    bit          chk_en = 0;
    bit          pending = 0;
    int          resp_edge = 0;
    int          next_free = 0;
    logic [31:0] exp_rd = 32'd0;
    logic        exp_err = 1'b0;
    logic [31:0] cur_rd = 32'd0;
    logic [31:0] last_rd = 32'd0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (pending && edge_n == resp_edge) begin
                check("ready_resp", {31'd0, ready}, 32'd1);
                check("rdata_resp", rdata, exp_rd);
                check("err_resp", {31'd0, err}, {31'd0, exp_err});
                cur_rd   = exp_rd;
                last_rd  = rdata;
                last_err = err;
                pending  = 0;
            end else begin
                check("ready_idle", {31'd0, ready}, 32'd0);
                check("err_idle", {31'd0, err}, 32'd0);
                check("rdata_hold", rdata, cur_rd);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 one cycle after the response.
    task automatic txn(input logic w, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] d, input bit hold, input bit lit,
                       input logic [31:0] lit_rd, input logic lit_err);
        int acc;
        logic [31:0] mr;
        logic me;
        model(w, a, f, d, mr, me);
        we = w; addr = a; f3 = f; wdata = d; req = 1'b1;
        acc = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
        exp_rd = mr; exp_err = me; resp_edge = acc + int'(LATENCY); pending = 1;
        while (edge_n < acc) begin @(posedge clk); #1; end
        if (!hold) req = 1'b0;
        while (edge_n < resp_edge) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        if (lit) begin
            check("lit_rdata", last_rd, lit_rd);
            check("lit_err", {31'd0, last_err}, {31'd0, lit_err});
        end
        @(posedge clk); #1;
        next_free = resp_edge + 2;
    endtask

    task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] d);
        int acc;
        we = 1'b1; addr = a; f3 = 3'b010; wdata = d; req = 1'b1;
        acc = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
        while (edge_n < acc) begin @(posedge clk); #1; end
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cur_rd = 32'd0;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        repeat (LATENCY + 3) begin @(posedge clk); #1; end
        next_free = 0;
    endtask

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        chk_en = 1;

        txn(1, 32'h10, W, 32'hDEADBEEF, 0, 1, 32'h0, 0);
        txn(0, 32'h10, W, 32'h0, 0, 1, 32'hDEADBEEF, 0);
        txn(0, 32'h13, B, 32'h0, 0, 1, 32'hFFFFFFDE, 0);
        txn(0, 32'h13, BU, 32'h0, 0, 1, 32'h000000DE, 0);
        txn(0, 32'h12, H, 32'h0, 0, 1, 32'hFFFFDEAD, 0);
        txn(0, 32'h12, HU, 32'h0, 0, 1, 32'h0000DEAD, 0);
        txn(0, 32'h10, B, 32'h0, 0, 1, 32'hFFFFFFEF, 0);

        txn(1, 32'h11, B, 32'h000000AA, 0, 0, 32'h0, 0);
        txn(0, 32'h10, W, 32'h0, 0, 1, 32'hDEADAAEF, 0);
        txn(1, 32'h12, H, 32'h00001234, 0, 0, 32'h0, 0);
        txn(0, 32'h10, W, 32'h0, 0, 1, 32'h1234AAEF, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
        txn(0, 32'h12, W, 32'h0, 0, 1, 32'h0, 1);
        txn(1, 32'h12, W, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
        txn(0, 32'h10, W, 32'h0, 0, 1, 32'h1234AAEF, 0);
        txn(0, 32'h11, H, 32'h0, 0, 1, 32'h0, 1);
`else
        txn(0, 32'h12, W, 32'h0, 0, 1, 32'h1234AAEF, 0);
        txn(0, 32'h11, H, 32'h0, 0, 1, 32'hFFFFAAEF, 0);
        txn(0, 32'h13, HU, 32'h0, 0, 1, 32'h00001234, 0);
`endif

        txn(0, 32'h400, W, 32'h0, 0, 1, 32'h0, 1);
        txn(0, 32'h80000010, W, 32'h0, 0, 1, 32'h0, 1);
        txn(0, 32'h10, 3'b011, 32'h0, 0, 1, 32'h0, 1);
        txn(1, 32'h10, 3'b100, 32'h00000077, 0, 1, 32'h0, 1);
        txn(1, 32'h10, 3'b110, 32'h00000077, 0, 1, 32'h0, 1);
        txn(0, 32'h10, W, 32'h0, 0, 1, 32'h1234AAEF, 0);

        txn(1, 32'h20, W, 32'h11223344, 0, 0, 32'h0, 0);
        reset_mid_store(32'h20, 32'h00000055);
        txn(0, 32'h20, W, 32'h0, 0, 1, 32'h11223344, 0);

        txn(0, 32'h10, W, 32'h0, 1, 0, 32'h0, 0);
        txn(0, 32'h20, W, 32'h0, 1, 0, 32'h0, 0);
        txn(1, 32'h24, HU, 32'h0, 1, 1, 32'h0, 1);
        txn(0, 32'h23, BU, 32'h0, 0, 1, 32'h00000011, 0);

        repeat (3) begin @(posedge clk); #1; end
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
